// File: rtl/fractal_pixel_scheduler.sv
// fractal_pixel_scheduler
//
// Hands out one frame of pixel jobs to NUM_ENGINES iteration engines and
// collects the iteration counts back in raster order.
// - Jobs go out round-robin, one per cycle at most.
// - Results are retired strictly in dispatch order, even when a later engine
//   finishes first.
// - Retired counts go to the colour/packer stage through a single output
//   register that carries sof/eol framing.
//
// Ports
//   aclk, areset  clock; asynchronous active-high reset
//   start         pulse that begins a frame; ignored unless idle
//   loop_en       1 = wrap back to (0,0) and keep running after each frame
//   abort         synchronous stop; drops every in-flight job
//   busy          scheduler is not idle
//   frame_done    one-cycle pulse after the last pixel of a frame is accepted
//   eng_start     one-hot job start; eng_x/eng_y carry the job coordinate
//   eng_done      per-engine result ready, held until eng_ack
//   eng_iter      packed iteration counts, engine i in bits [8i+7:8i]
//   eng_ack       one-hot result consume
//   pix_*         output pixel stream (valid/ready, iteration count, sof, eol)

module fractal_pixel_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int X_SIZE      = 640,
  parameter int Y_SIZE      = 480
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     start,
  input  logic                     loop_en,
  input  logic                     abort,
  output logic                     busy,
  output logic                     frame_done,
  output logic [NUM_ENGINES-1:0]   eng_start,
  output logic [15:0]              eng_x,
  output logic [15:0]              eng_y,
  input  logic [NUM_ENGINES-1:0]   eng_done,
  input  logic [8*NUM_ENGINES-1:0] eng_iter,
  output logic [NUM_ENGINES-1:0]   eng_ack,
  output logic [7:0]               pix_iter,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     pix_sof,
  output logic                     pix_eol
);

  localparam int          IW    = $clog2(NUM_ENGINES);
  localparam logic [15:0] XLAST = 16'(X_SIZE - 1);
  localparam logic [15:0] YLAST = 16'(Y_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          dispPtr_q, dispPtr_d;
  logic [IW-1:0]          retPtr_q, retPtr_d;
  logic [NUM_ENGINES-1:0] occupied_q, occupied_d;
  logic [15:0]            dispX_q, dispX_d, dispY_q, dispY_d;
  logic [15:0]            retX_q, retX_d, retY_q, retY_d;
  logic                   pixValid_q, pixValid_d;
  logic [7:0]             pixIter_q, pixIter_d;
  logic                   pixSof_q, pixSof_d;
  logic                   pixEol_q, pixEol_d;
  logic                   pixLast_q, pixLast_d;
  logic                   frameDone_q, frameDone_d;

  // All scheduler state lives in this one register bank. Reset puts
  // everything back to the start of an empty frame.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      dispPtr_q   <= '0;
      retPtr_q    <= '0;
      occupied_q  <= '0;
      dispX_q     <= '0;
      dispY_q     <= '0;
      retX_q      <= '0;
      retY_q      <= '0;
      pixValid_q  <= 1'b0;
      pixIter_q   <= '0;
      pixSof_q    <= 1'b0;
      pixEol_q    <= 1'b0;
      pixLast_q   <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dispPtr_q   <= dispPtr_d;
      retPtr_q    <= retPtr_d;
      occupied_q  <= occupied_d;
      dispX_q     <= dispX_d;
      dispY_q     <= dispY_d;
      retX_q      <= retX_d;
      retY_q      <= retY_d;
      pixValid_q  <= pixValid_d;
      pixIter_q   <= pixIter_d;
      pixSof_q    <= pixSof_d;
      pixEol_q    <= pixEol_d;
      pixLast_q   <= pixLast_d;
      frameDone_q <= frameDone_d;
    end
  end

  // Next-state logic. Abort wins over everything: it clears the counters
  // and acks any engine currently holding a result so that none is left
  // hanging. Otherwise, each cycle may dispatch one job (RUN only) and
  // retire one result (RUN or DRAIN). The retire check uses the registered
  // occupancy, so an engine retired this cycle can be re-dispatched no
  // earlier than the next cycle. frame_done is registered from the accept
  // of the frame's last pixel, which lines it up with the cycle in which
  // DRAIN sees everything empty.
  always_comb begin
    state_d     = state_q;
    dispPtr_d   = dispPtr_q;
    retPtr_d    = retPtr_q;
    occupied_d  = occupied_q;
    dispX_d     = dispX_q;
    dispY_d     = dispY_q;
    retX_d      = retX_q;
    retY_d      = retY_q;
    pixValid_d  = pixValid_q;
    pixIter_d   = pixIter_q;
    pixSof_d    = pixSof_q;
    pixEol_d    = pixEol_q;
    pixLast_d   = pixLast_q;
    frameDone_d = 1'b0;
    eng_start   = '0;
    eng_ack     = '0;
    eng_x       = '0;
    eng_y       = '0;

    if (abort) begin
      state_d    = S_IDLE;
      dispPtr_d  = '0;
      retPtr_d   = '0;
      occupied_d = '0;
      dispX_d    = '0;
      dispY_d    = '0;
      retX_d     = '0;
      retY_d     = '0;
      pixValid_d = 1'b0;
      eng_ack    = eng_done;
    end else begin
      if (pixValid_q && pix_ready) begin
        pixValid_d  = 1'b0;
        frameDone_d = pixLast_q;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
          end
        end
        S_DRAIN: begin
          if ((occupied_q == '0) && !pixValid_q) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          if (!occupied_q[dispPtr_q]) begin
            eng_start[dispPtr_q]  = 1'b1;
            eng_x                 = dispX_q;
            eng_y                 = dispY_q;
            occupied_d[dispPtr_q] = 1'b1;
            dispPtr_d             = dispPtr_q + 1'b1;
            if (dispX_q == XLAST) begin
              dispX_d = '0;
              if (dispY_q == YLAST) begin
                dispY_d = '0;
                if (!loop_en) begin
                  state_d = S_DRAIN;
                end
              end else begin
                dispY_d = dispY_q + 16'd1;
              end
            end else begin
              dispX_d = dispX_q + 16'd1;
            end
          end
        end
      endcase

      if ((state_q != S_IDLE) && occupied_q[retPtr_q] && eng_done[retPtr_q] &&
          (!pixValid_q || pix_ready)) begin
        eng_ack[retPtr_q]    = 1'b1;
        occupied_d[retPtr_q] = 1'b0;
        retPtr_d             = retPtr_q + 1'b1;
        pixValid_d           = 1'b1;
        pixIter_d            = eng_iter[{retPtr_q, 3'b000} +: 8];
        pixSof_d             = (retX_q == '0) && (retY_q == '0);
        pixEol_d             = (retX_q == XLAST);
        pixLast_d            = (retX_q == XLAST) && (retY_q == YLAST);
        if (retX_q == XLAST) begin
          retX_d = '0;
          retY_d = (retY_q == YLAST) ? '0 : retY_q + 16'd1;
        end else begin
          retX_d = retX_q + 16'd1;
        end
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign frame_done = frameDone_q;
  assign pix_valid  = pixValid_q;
  assign pix_iter   = pixIter_q;
  assign pix_sof    = pixSof_q;
  assign pix_eol    = pixEol_q;

endmodule

// File: tb/tb_fractal_pixel_scheduler.sv
// tb_fractal_pixel_scheduler
//
// Directed bench for fractal_pixel_scheduler with a 4-engine, 4x2 frame.
// A behavioural engine model answers each job after a per-engine latency
// with a count derived from the job coordinate, so every pixel leaving
// the scheduler has a known expected value and position.

module tb_fractal_pixel_scheduler;

  localparam int N  = 4;
  localparam int XS = 4;
  localparam int YS = 2;

  logic           aclk = 1'b0;
  logic           areset;
  logic           start;
  logic           loop_en;
  logic           abort;
  logic           busy;
  logic           frame_done;
  logic [N-1:0]   eng_start;
  logic [15:0]    eng_x;
  logic [15:0]    eng_y;
  logic [N-1:0]   eng_done = '0;
  logic [8*N-1:0] eng_iter = '0;
  logic [N-1:0]   eng_ack;
  logic [7:0]     pix_iter;
  logic           pix_valid;
  logic           pix_ready;
  logic           pix_sof;
  logic           pix_eol;

  int testCount = 0;
  int failCount = 0;

  int       lat[N]     = '{default: 1};
  int       cnt[N]     = '{default: 0};
  logic [7:0] jobIter[N] = '{default: 8'h00};
  bit       engFlush   = 1'b0;

  int expDx, expDy, expRx, expRy, expDp, expRp;
  int dispCount, retCount, accCount, fdCount, sofCount;
  bit pendFd;

  always #5 aclk = ~aclk;

  fractal_pixel_scheduler #(
    .NUM_ENGINES(N),
    .X_SIZE     (XS),
    .Y_SIZE     (YS)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .start     (start),
    .loop_en   (loop_en),
    .abort     (abort),
    .busy      (busy),
    .frame_done(frame_done),
    .eng_start (eng_start),
    .eng_x     (eng_x),
    .eng_y     (eng_y),
    .eng_done  (eng_done),
    .eng_iter  (eng_iter),
    .eng_ack   (eng_ack),
    .pix_iter  (pix_iter),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol)
  );

  // Iteration count the engine model reports for a pixel.
  function automatic logic [7:0] pixVal(input int x, input int y);
    return 8'(y * 16 + x + 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearScore();
    expDx = 0; expDy = 0; expRx = 0; expRy = 0; expDp = 0; expRp = 0;
    dispCount = 0; retCount = 0; accCount = 0; fdCount = 0; sofCount = 0;
    pendFd = 1'b0;
  endtask

  // Sets per-engine latencies and loop mode, then pulses start for one cycle.
  task automatic applyStimulus(input int l0, input int l1, input int l2, input int l3,
                               input bit loopMode);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    loop_en = loopMode;
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (busy && n < budget);
    checkOutput("idleTimeout", 32'(busy), 32'd0);
  endtask

  // Engine model: observes starts and acks mid-cycle, applies them just
  // after the following clock edge so the DUT sees stable inputs.
  always begin : engineModel
    logic [N-1:0] st, ak;
    logic [15:0]  sx, sy;
    @(negedge aclk);
    st = eng_start; ak = eng_ack; sx = eng_x; sy = eng_y;
    @(posedge aclk); #1;
    for (int i = 0; i < N; i++) begin
      if (engFlush) begin
        cnt[i] = 0;
        eng_done[i] = 1'b0;
      end else begin
        if (ak[i]) eng_done[i] = 1'b0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) eng_done[i] = 1'b1;
        end
        if (st[i]) begin
          jobIter[i] = pixVal(int'(sx), int'(sy));
          cnt[i] = lat[i];
        end
      end
      eng_iter[8*i +: 8] = jobIter[i];
    end
  end

  // Scoreboard: dispatch order/coordinates, ack order, output pixels and
  // the frame_done pulse following the last accepted pixel of each frame.
  always @(negedge aclk) begin
    if (!areset && !abort) begin
      if (frame_done || pendFd) checkOutput("frameDone", 32'(frame_done), 32'(pendFd));
      if (frame_done) fdCount++;
      pendFd = 1'b0;
      if (eng_start != '0) begin
        checkOutput("dispEngine", 32'(eng_start), 32'(1) << expDp);
        checkOutput("dispXY", {eng_x, eng_y}, {expDx[15:0], expDy[15:0]});
        dispCount++;
        expDp = (expDp + 1) % N;
        if (expDx == XS - 1) begin
          expDx = 0;
          expDy = (expDy == YS - 1) ? 0 : expDy + 1;
        end else begin
          expDx++;
        end
      end
      if (eng_ack != '0) begin
        checkOutput("ackOrder", 32'(eng_ack), 32'(1) << expRp);
        expRp = (expRp + 1) % N;
        retCount++;
      end
      if (pix_valid && pix_ready) begin
        checkOutput("pixIter", 32'(pix_iter), 32'(pixVal(expRx, expRy)));
        checkOutput("pixFlags", 32'({pix_sof, pix_eol}),
                    32'({(expRx == 0) && (expRy == 0), expRx == XS - 1}));
        if (pix_sof) sofCount++;
        pendFd = (expRx == XS - 1) && (expRy == YS - 1);
        accCount++;
        if (expRx == XS - 1) begin
          expRx = 0;
          expRy = (expRy == YS - 1) ? 0 : expRy + 1;
        end else begin
          expRx++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    clearScore();
    areset = 1'b1; start = 1'b0; loop_en = 1'b0; abort = 1'b0; pix_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstPixValid", 32'(pix_valid), 32'd0);
    checkOutput("rstEngStart", 32'(eng_start), 32'd0);
    checkOutput("rstFrameDone", 32'(frame_done), 32'd0);
    areset = 1'b0;
    @(posedge aclk); #1;

    // Basic frame: 8 pixels in raster order, one frame_done.
    $display("[TB] basic frame");
    applyStimulus(3, 3, 3, 3, 1'b0);
    @(negedge aclk);
    checkOutput("startLatency", 32'(eng_start), 32'd1);
    waitIdle(300);
    checkOutput("t1Pixels", accCount, 8);
    checkOutput("t1Frames", fdCount, 1);
    checkOutput("t1Sof", sofCount, 1);

    // Engine 1 finishes long before engine 0: output order must not change.
    $display("[TB] out-of-order completion");
    @(posedge aclk); #1;
    clearScore();
    applyStimulus(10, 2, 2, 2, 1'b0);
    waitIdle(400);
    checkOutput("t2Pixels", accCount, 8);
    checkOutput("t2Frames", fdCount, 1);

    // Downstream stall mid-frame.
    $display("[TB] downstream stall");
    @(posedge aclk); #1;
    clearScore();
    applyStimulus(2, 2, 2, 2, 1'b0);
    n = 0;
    while (accCount < 2 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("t3Reach", 32'(accCount >= 2), 32'd1);
    @(posedge aclk); #1;
    pix_ready = 1'b0;
    repeat (5) @(negedge aclk);
    repeat (15) begin
      @(negedge aclk);
      checkOutput("stallValid", 32'(pix_valid), 32'd1);
      checkOutput("stallIter", 32'(pix_iter), 32'(pixVal(expRx, expRy)));
      checkOutput("stallAck", 32'(eng_ack), 32'd0);
      checkOutput("stallInflight", 32'((dispCount - retCount) <= N), 32'd1);
    end
    @(posedge aclk); #1;
    pix_ready = 1'b1;
    waitIdle(300);
    checkOutput("t3Pixels", accCount, 8);
    checkOutput("t3Frames", fdCount, 1);

    // Abort with jobs in flight, engine 0 holding a result, pixel pending.
    $display("[TB] abort");
    @(posedge aclk); #1;
    clearScore();
    pix_ready = 1'b0;
    applyStimulus(1, 30, 30, 30, 1'b0);
    repeat (12) @(posedge aclk);
    #1;
    abort = 1'b1;
    @(negedge aclk);
    checkOutput("abortAck", 32'(eng_ack), 32'b0001);
    checkOutput("abortPixBefore", 32'(pix_valid), 32'd1);
    @(posedge aclk); #1;
    abort = 1'b0;
    @(negedge aclk);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortPixValid", 32'(pix_valid), 32'd0);
    checkOutput("abortFrameDone", 32'(frame_done), 32'd0);
    checkOutput("abortEngStart", 32'(eng_start), 32'd0);
    engFlush = 1'b1;
    pix_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    engFlush = 1'b0;
    clearScore();

    // Looping: frame_done every 8th pixel, stays busy, then stops cleanly.
    $display("[TB] loop mode");
    applyStimulus(1, 1, 1, 1, 1'b1);
    n = 0;
    while (fdCount < 3 && n < 400) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("loopReach", 32'(fdCount >= 3), 32'd1);
    checkOutput("loopBusy", 32'(busy), 32'd1);
    checkOutput("loopSof", 32'(sofCount >= 3), 32'd1);
    @(posedge aclk); #1;
    loop_en = 1'b0;
    waitIdle(300);
    checkOutput("loopWhole", accCount % 8, 0);
    checkOutput("loopFrames", fdCount, accCount / 8);

    // Asynchronous reset during DRAIN, then a fresh frame.
    $display("[TB] reset during drain");
    @(posedge aclk); #1;
    clearScore();
    applyStimulus(1, 1, 1, 1, 1'b0);
    n = 0;
    while (dispCount < 8 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    @(posedge aclk);
    #2;
    checkOutput("drainBusy", 32'(busy), 32'd1);
    #1;
    areset = 1'b1;
    #1;
    checkOutput("arstBusy", 32'(busy), 32'd0);
    checkOutput("arstPixValid", 32'(pix_valid), 32'd0);
    checkOutput("arstFrameDone", 32'(frame_done), 32'd0);
    checkOutput("arstEngStart", 32'(eng_start), 32'd0);
    checkOutput("arstEngAck", 32'(eng_ack), 32'd0);
    checkOutput("arstPix", 32'({pix_iter, pix_sof, pix_eol}), 32'd0);
    engFlush = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    engFlush = 1'b0;
    clearScore();
    @(posedge aclk); #1;
    applyStimulus(1, 1, 1, 1, 1'b0);
    waitIdle(300);
    checkOutput("t6Pixels", accCount, 8);
    checkOutput("t6Frames", fdCount, 1);
    checkOutput("t6Sof", sofCount, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
